wifi_tx_interleaver_ctrl: RTL and testbench
===========================================

# wifi_tx_interleaver_ctrl

Frame sequencer for the WIFI TX 192-bit interleaver. It takes the coded bit stream from the convolutional encoder or puncturer over a ready/valid handshake and feeds it to the interleaver as one uninterrupted frame: 48 SIGNAL bits, then `n_sym` DATA symbols of 192 bits each. It then drives the interleaver's readout, counts the interleaved output bits and reports done or error to the TX top-level FSM.

## Interface
- `NCBPS`, 192, coded bits per DATA symbol
- `NCBPS_S`, 48, coded bits in the SIGNAL symbol
- `MAX_SYM`, 64, largest DATA symbol count that fits the interleaver RAM
- `NSYM_W`, 8, width of `n_sym`
- `TIMEOUT`, 1023, watchdog limit in cycles, per wait state

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-low
- `start`  in  1  one-cycle pulse that begins a frame; sampled only in IDLE
- `n_sym`  in  NSYM_W  DATA symbol count; latched on an accepted `start`
- `src_valid`  in  1  upstream bit valid
- `src_data`  in  1  upstream coded bit
- `src_ready`  out  1  controller can accept a bit
- `il_enable`  out  1  to interleaver `enable`
- `il_valid_in`  out  1  to interleaver `valid_in`
- `il_data_in`  out  1  to interleaver `data_in`
- `il_valid_out`  in  1  from interleaver `valid_out`
- `il_finished`  in  1  from interleaver `finished`
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse on a successful frame
- `error`  out  1  one-cycle pulse on a length fault, timeout or count mismatch
- `out_cnt`  out  16  interleaved bits counted in the current frame

## Operation
States: IDLE, LOAD_SIG, LOAD_DATA, DRAIN, WAIT_FIN, DONE.

- **IDLE**
  - `start`=1 and `n_sym` ≤ MAX_SYM: latch `n_sym`, compute `exp_cnt = NCBPS_S + NCBPS*n_sym` (16 bits), clear all counters, go to LOAD_SIG.
  - `start`=1 and `n_sym` > MAX_SYM: pulse `error` and stay in IDLE.
- **LOAD_SIG / LOAD_DATA**
  - `src_ready`=1.
  - A transfer is `src_valid & src_ready`.
  - On a transfer, the registered outputs update next cycle: `il_valid_in`=1, `il_enable`=1, `il_data_in`=`src_data`.
  - On a non-transfer cycle: `il_valid_in`=0 and `il_enable`=0. This freezes the interleaver, so upstream gaps never trigger a premature readout.
  - `bit_cnt` counts transfers. LOAD_SIG leaves at transfer 48. If `n_sym`=0 it goes to DRAIN; otherwise it goes to LOAD_DATA.
  - LOAD_DATA wraps `bit_cnt` at 192 and increments `sym_cnt`. It goes to DRAIN on the last bit of symbol `n_sym`.
- **DRAIN**
  - `src_ready`=0, `il_valid_in`=0, `il_enable`=1.
  - Go to WAIT_FIN on the first `il_valid_out`=1.
- **WAIT_FIN**
  - `il_enable`=1.
  - Go to DONE on a rising edge of `il_finished` (registered previous value 0, current value 1).
- **DONE**
  - If `out_cnt` == `exp_cnt`, pulse `done`; otherwise pulse `error`.
  - Return to IDLE with `il_enable`=0.
- **Output counting**: `out_cnt` increments on every `il_valid_out`=1 from LOAD_SIG through WAIT_FIN. It holds its value in IDLE until the next accepted `start`.
- **Watchdog**: counts cycles spent in DRAIN and in WAIT_FIN, and resets on each state entry. Reaching TIMEOUT pulses `error`, forces `il_enable`=0 and returns to IDLE.
- **`start` while busy** is ignored.
- **Reset**: synchronous reset in any state returns to IDLE immediately. The interleaver shares the same reset, so no partial frame survives.

## Timing
- Reset values:
  - `src_ready`=0, `il_enable`=0, `il_valid_in`=0, `il_data_in`=0
  - `busy`=0, `done`=0, `error`=0, `out_cnt`=0
- `src_ready` is combinational from state; all other outputs are registered.
- `start` → `src_ready`=1: 1 cycle.
- Transfer → `il_valid_in`: 1 cycle.
- The last transfer is followed by `il_valid_in`=0 with `il_enable`=1 on the next cycle, which starts the interleaver readout.
- `done`/`error`: asserted exactly 1 cycle after the `il_finished` rising edge is seen in WAIT_FIN. Each pulse lasts 1 cycle.
- `busy` rises the cycle after an accepted `start`. It falls in the cycle after DONE or after an error exit.
- Minimum frame (`n_sym`=0, no gaps) takes 48 load cycles, plus the interleaver readout, plus 2.

## Test plan
- `n_sym`=0, 48 bits back-to-back → `il_valid_in` high for exactly 48 cycles; `out_cnt`=48; single `done` pulse, no `error`.
- `n_sym`=2, random `src_valid` gaps → `il_enable`=0 during every gap; 432 bits written; `out_cnt`=432; `done`; output bit order matches the golden interleaver model.
- `n_sym`=MAX_SYM+1 → `error` 1 cycle after `start`; `busy` stays 0; `src_ready` stays 0.
- Stub interleaver that never raises `il_finished` → `error` after TIMEOUT cycles in WAIT_FIN; `il_enable`=0; IDLE; a subsequent frame completes normally.
- `reset`=0 asserted mid-LOAD_DATA → next edge: all outputs at reset values; a new `n_sym`=1 frame gives `out_cnt`=240 and `done`.
- `start` pulsed during DRAIN → ignored; `exp_cnt` unchanged; a single `done`.

Source files
------------

// File: rtl/wifi_tx_interleaver_ctrl.sv
// wifi_tx_interleaver_ctrl
//   Frame sequencer for the WIFI TX 192-bit interleaver. Accepts coded bits
//   over a ready/valid handshake and writes them into the interleaver as one
//   frame: a 48-bit SIGNAL symbol followed by n_sym DATA symbols of 192 bits.
//   It then keeps the interleaver enabled through readout, counts the
//   interleaved bits and reports done/error to the TX top-level FSM.
//
// Ports
//   clk, reset          single clock, synchronous active-low reset
//   start, n_sym        frame request (sampled in IDLE) and DATA symbol count
//   src_valid/data/ready  upstream coded-bit handshake (src_ready is combinational)
//   il_enable, il_valid_in, il_data_in   registered interleaver write controls
//   il_valid_out, il_finished            interleaver readout status
//   busy, done, error   registered status; done/error are one-cycle pulses
//   out_cnt             interleaved bits counted in the current frame
module wifi_tx_interleaver_ctrl #(
  parameter int unsigned NCBPS   = 192,
  parameter int unsigned NCBPS_S = 48,
  parameter int unsigned MAX_SYM = 64,
  parameter int unsigned NSYM_W  = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NSYM_W-1:0] n_sym,
  input  logic              src_valid,
  input  logic              src_data,
  output logic              src_ready,
  output logic              il_enable,
  output logic              il_valid_in,
  output logic              il_data_in,
  input  logic              il_valid_out,
  input  logic              il_finished,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       out_cnt
);

  localparam int unsigned BIT_W = $clog2(NCBPS + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SIG,
    LOAD_DATA,
    DRAIN,
    WAIT_FIN,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [NSYM_W-1:0]   nsym_q;
  logic [NSYM_W-1:0]   sym_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [15:0]         exp_cnt;
  logic [WD_W-1:0]     wd_cnt;
  logic                fin_q;

  logic                xfer;
  logic                accept;
  logic                len_fault;
  logic                sig_last;
  logic                sym_last_bit;
  logic                data_last;
  logic                fin_rise;
  logic                wd_expired;
  logic                cnt_en;
  logic [15:0]         out_cnt_nxt;
  logic                en_d, vin_d, din_d, done_d, err_d;

  assign src_ready    = (state == LOAD_SIG) || (state == LOAD_DATA);
  assign xfer         = src_valid & src_ready;
  assign len_fault    = n_sym > NSYM_W'(MAX_SYM);
  assign accept       = (state == IDLE) && start && !len_fault;
  assign sig_last     = bit_cnt == BIT_W'(NCBPS_S - 1);
  assign sym_last_bit = bit_cnt == BIT_W'(NCBPS - 1);
  assign data_last    = sym_last_bit && ((sym_cnt + NSYM_W'(1)) == nsym_q);
  assign fin_rise     = il_finished & ~fin_q;
  assign wd_expired   = wd_cnt == WD_W'(TIMEOUT - 1);
  assign cnt_en       = state inside {LOAD_SIG, LOAD_DATA, DRAIN, WAIT_FIN};
  assign out_cnt_nxt  = out_cnt + ((cnt_en && il_valid_out) ? 16'd1 : 16'd0);

  always_comb begin
    state_d = state;
    en_d    = 1'b0;
    vin_d   = 1'b0;
    din_d   = il_data_in;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_fault) err_d   = 1'b1;
          else           state_d = LOAD_SIG;
        end
      end
      LOAD_SIG, LOAD_DATA: begin
        // Enable follows the handshake so upstream gaps freeze the interleaver.
        if (xfer) begin
          en_d  = 1'b1;
          vin_d = 1'b1;
          din_d = src_data;
          if (state == LOAD_SIG && sig_last)
            state_d = (nsym_q == '0) ? DRAIN : LOAD_DATA;
          else if (state == LOAD_DATA && data_last)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        en_d = 1'b1;
        if (il_valid_out) begin
          state_d = WAIT_FIN;
        end else if (wd_expired) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_FIN: begin
        en_d = 1'b1;
        if (fin_rise) begin
          // Verdict registered on entry to DONE so the pulse lands one cycle
          // after the finished edge; includes any bit counted on this edge.
          state_d = DONE;
          done_d  = (out_cnt_nxt == exp_cnt);
          err_d   = (out_cnt_nxt != exp_cnt);
        end else if (wd_expired) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      nsym_q      <= '0;
      sym_cnt     <= '0;
      bit_cnt     <= '0;
      exp_cnt     <= '0;
      wd_cnt      <= '0;
      fin_q       <= 1'b0;
      out_cnt     <= '0;
      il_enable   <= 1'b0;
      il_valid_in <= 1'b0;
      il_data_in  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      fin_q       <= il_finished;
      il_enable   <= en_d;
      il_valid_in <= vin_d;
      il_data_in  <= din_d;
      busy        <= (state_d != IDLE);
      done        <= done_d;
      error       <= err_d;

      if (accept) begin
        nsym_q  <= n_sym;
        exp_cnt <= 16'(NCBPS_S) + 16'(NCBPS) * 16'(n_sym);
        sym_cnt <= '0;
        bit_cnt <= '0;
        out_cnt <= '0;
      end else begin
        out_cnt <= out_cnt_nxt;
        if (xfer) begin
          if (state == LOAD_SIG) begin
            bit_cnt <= sig_last ? '0 : bit_cnt + BIT_W'(1);
          end else if (sym_last_bit) begin
            bit_cnt <= '0;
            sym_cnt <= sym_cnt + NSYM_W'(1);
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
      end

      if (state_d != state)
        wd_cnt <= '0;
      else if (state == DRAIN || state == WAIT_FIN)
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_wifi_tx_interleaver_ctrl.sv
// tb_wifi_tx_interleaver_ctrl
//   Bench for wifi_tx_interleaver_ctrl. A behavioural interleaver stub and a
//   random bit source are stepped once per cycle on the falling clock edge;
//   frame-level expectations come from the frame length arithmetic.
module tb_wifi_tx_interleaver_ctrl;

  localparam int NCBPS   = 192;
  localparam int NCBPS_S = 48;
  localparam int MAX_SYM = 64;
  localparam int NSYM_W  = 8;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [NSYM_W-1:0] n_sym = '0;
  logic              src_valid = 1'b0;
  logic              src_data = 1'b0;
  logic              src_ready;
  logic              il_enable;
  logic              il_valid_in;
  logic              il_data_in;
  logic              il_valid_out = 1'b0;
  logic              il_finished = 1'b0;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       out_cnt;

  wifi_tx_interleaver_ctrl #(
    .NCBPS   (NCBPS),
    .NCBPS_S (NCBPS_S),
    .MAX_SYM (MAX_SYM),
    .NSYM_W  (NSYM_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .n_sym        (n_sym),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .il_enable    (il_enable),
    .il_valid_in  (il_valid_in),
    .il_data_in   (il_data_in),
    .il_valid_out (il_valid_out),
    .il_finished  (il_finished),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .out_cnt      (out_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  bit          wr_q[$];
  bit          sent_q[$];
  int          exp_bits;
  int          src_left;
  bit          frame_on;
  bit          gaps_on;
  bit          never_fin;
  int          gap_viol;
  int          vin_cnt;
  int          n_done;
  int          n_err;
  int          done_cyc;
  int          err_cyc;
  int          fin_cyc;
  int          first_vo_cyc;
  logic [15:0] out_at_end;
  bit          rd_active;
  bit          rd_done;
  int          rd_left;
  int          rd_delay;
  int          rd_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    wr_q.delete();
    sent_q.delete();
    exp_bits     = 0;
    src_left     = 0;
    frame_on     = 1'b0;
    gap_viol     = 0;
    vin_cnt      = 0;
    n_done       = 0;
    n_err        = 0;
    done_cyc     = -1;
    err_cyc      = -1;
    fin_cyc      = -1;
    first_vo_cyc = -1;
    out_at_end   = '0;
    rd_active    = 1'b0;
    rd_done      = 1'b0;
    rd_left      = 0;
    rd_delay     = 0;
    rd_cnt       = 0;
  endtask

  // One cycle: observe registered outputs, step the interleaver stub, drive the source.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset) begin
      if (il_valid_in && il_enable) begin
        wr_q.push_back(il_data_in);
        vin_cnt++;
      end
      if (il_valid_in && !il_enable) gap_viol++;
      if (frame_on && il_enable && !il_valid_in && wr_q.size() < exp_bits) gap_viol++;
      if (done) begin
        n_done++;
        done_cyc   = cyc;
        out_at_end = out_cnt;
      end
      if (error) begin
        n_err++;
        err_cyc    = cyc;
        out_at_end = out_cnt;
      end
    end

    il_valid_out = 1'b0;
    il_finished  = 1'b0;
    if (reset && !rd_active && !rd_done && il_enable && !il_valid_in && wr_q.size() > 0) begin
      rd_active = 1'b1;
      rd_left   = wr_q.size();
      rd_delay  = 2;
    end
    if (reset && rd_active && il_enable) begin
      if (rd_delay > 0) begin
        rd_delay--;
      end else if (rd_left > 0) begin
        il_valid_out = 1'b1;
        rd_left--;
        rd_cnt++;
        if (first_vo_cyc < 0) first_vo_cyc = cyc;
      end else begin
        il_finished = !never_fin;
        if (!never_fin) fin_cyc = cyc;
        rd_active = 1'b0;
        rd_done   = 1'b1;
      end
    end

    src_valid = 1'b0;
    if (reset && src_left > 0) begin
      src_valid = gaps_on ? ($urandom_range(3) != 0) : 1'b1;
      src_data  = 1'($urandom_range(1));
      if (src_valid && src_ready) begin
        sent_q.push_back(src_data);
        src_left--;
      end
    end
  endtask

  task automatic run_frame(input int n, input bit gaps, input bit inj, input bit nf, input string nm);
    int budget;
    int order_bad;
    bit injected;
    clear_model();
    exp_bits  = NCBPS_S + NCBPS * n;
    src_left  = exp_bits;
    frame_on  = 1'b1;
    gaps_on   = gaps;
    never_fin = nf;
    injected  = 1'b0;
    start     = 1'b1;
    n_sym     = NSYM_W'(n);
    tick();
    start = 1'b0;
    check_eq({nm, ":src_ready_rise"}, 32'(src_ready), 1);
    check_eq({nm, ":busy_rise"}, 32'(busy), 1);

    budget = 4 * exp_bits + TIMEOUT + 200;
    while (n_done == 0 && n_err == 0 && budget > 0) begin
      if (inj && !injected && wr_q.size() == exp_bits) begin
        start    = 1'b1;
        n_sym    = NSYM_W'(n + 2);
        injected = 1'b1;
      end
      tick();
      start = 1'b0;
      budget--;
    end
    check_eq({nm, ":terminated"}, 32'(budget > 0), 1);

    if (nf) begin
      check_eq({nm, ":timeout_err"}, 32'(n_err), 1);
      check_eq({nm, ":timeout_done"}, 32'(n_done), 0);
      check_eq({nm, ":timeout_delay_ok"},
               32'((err_cyc - first_vo_cyc) >= TIMEOUT && (err_cyc - first_vo_cyc) <= TIMEOUT + 2), 1);
      check_eq({nm, ":timeout_enable"}, 32'(il_enable), 0);
      check_eq({nm, ":timeout_busy"}, 32'(busy), 0);
    end else begin
      check_eq({nm, ":done_cnt"}, 32'(n_done), 1);
      check_eq({nm, ":err_cnt"}, 32'(n_err), 0);
      check_eq({nm, ":out_cnt"}, 32'(out_at_end), 32'(exp_bits));
      check_eq({nm, ":done_latency"}, 32'(done_cyc - fin_cyc), 1);
      check_eq({nm, ":busy_at_done"}, 32'(busy), 1);
    end

    order_bad = 0;
    for (int i = 0; i < wr_q.size() && i < sent_q.size(); i++)
      if (wr_q[i] != sent_q[i]) order_bad++;
    check_eq({nm, ":bits_sent"}, 32'(sent_q.size()), 32'(exp_bits));
    check_eq({nm, ":bits_written"}, 32'(vin_cnt), 32'(exp_bits));
    check_eq({nm, ":bit_order"}, 32'(order_bad), 0);
    check_eq({nm, ":gap_enable"}, 32'(gap_viol), 0);
    check_eq({nm, ":readout_len"}, 32'(rd_cnt), 32'(exp_bits));

    frame_on = 1'b0;
    tick();
    check_eq({nm, ":busy_fall"}, 32'(busy), 0);
    check_eq({nm, ":idle_enable"}, 32'(il_enable), 0);
    check_eq({nm, ":idle_ready"}, 32'(src_ready), 0);
    repeat (3) tick();
    check_eq({nm, ":single_pulse"}, 32'(n_done + n_err), 1);
  endtask

  initial begin
    int budget;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    clear_model();
    gaps_on   = 1'b0;
    never_fin = 1'b0;

    reset = 1'b0;
    repeat (3) tick();
    check_eq("rst:src_ready", 32'(src_ready), 0);
    check_eq("rst:il_enable", 32'(il_enable), 0);
    check_eq("rst:il_valid_in", 32'(il_valid_in), 0);
    check_eq("rst:il_data_in", 32'(il_data_in), 0);
    check_eq("rst:busy", 32'(busy), 0);
    check_eq("rst:done", 32'(done), 0);
    check_eq("rst:error", 32'(error), 0);
    check_eq("rst:out_cnt", 32'(out_cnt), 0);
    reset = 1'b1;
    tick();

    // Oversized frame request
    start = 1'b1;
    n_sym = NSYM_W'(MAX_SYM + 1);
    tick();
    start = 1'b0;
    check_eq("len_fault:error", 32'(error), 1);
    check_eq("len_fault:busy", 32'(busy), 0);
    check_eq("len_fault:src_ready", 32'(src_ready), 0);
    tick();
    check_eq("len_fault:error_pulse", 32'(error), 0);
    check_eq("len_fault:busy_after", 32'(busy), 0);
    check_eq("len_fault:ready_after", 32'(src_ready), 0);

    run_frame(0, 1'b0, 1'b0, 1'b0, "nsym0");
    run_frame(2, 1'b1, 1'b0, 1'b0, "nsym2_gaps");
    repeat (4) run_frame(int'($urandom_range(4, 1)), 1'b1, 1'b0, 1'b0, "rand");
    run_frame(0, 1'b0, 1'b0, 1'b1, "timeout");
    run_frame(1, 1'b1, 1'b0, 1'b0, "after_timeout");
    run_frame(1, 1'b1, 1'b1, 1'b0, "start_in_drain");

    // Largest legal frame is accepted, then reset lands mid-LOAD_DATA
    clear_model();
    exp_bits = NCBPS_S + NCBPS * MAX_SYM;
    src_left = exp_bits;
    frame_on = 1'b1;
    gaps_on  = 1'b1;
    start    = 1'b1;
    n_sym    = NSYM_W'(MAX_SYM);
    tick();
    start = 1'b0;
    check_eq("max_sym:accepted_busy", 32'(busy), 1);
    check_eq("max_sym:accepted_ready", 32'(src_ready), 1);
    check_eq("max_sym:no_error", 32'(error), 0);
    budget = 1000;
    while (wr_q.size() < 100 && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("mid_load:reached", 32'(budget > 0), 1);
    reset = 1'b0;
    tick();
    check_eq("mid_rst:src_ready", 32'(src_ready), 0);
    check_eq("mid_rst:il_enable", 32'(il_enable), 0);
    check_eq("mid_rst:il_valid_in", 32'(il_valid_in), 0);
    check_eq("mid_rst:il_data_in", 32'(il_data_in), 0);
    check_eq("mid_rst:busy", 32'(busy), 0);
    check_eq("mid_rst:done", 32'(done), 0);
    check_eq("mid_rst:error", 32'(error), 0);
    check_eq("mid_rst:out_cnt", 32'(out_cnt), 0);
    reset = 1'b1;
    clear_model();
    tick();
    run_frame(1, 1'b1, 1'b0, 1'b0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
